// File: rtl/text_render.sv
// text_render: 8x16 text-mode renderer. Looks up each pixel's character and glyph row
// through a 4-stage pipeline and emits RGB with syncs delayed to match, plus a blinking cursor.
module text_render #(
   parameter int         COLS         = 60,
   parameter int         ROWS         = 17,
   parameter int         X0           = 0,
   parameter int         Y0           = 0,
   parameter logic [2:0] FG           = 3'b111,
   parameter logic [2:0] BG           = 3'b000,
   parameter int         BLINK_FRAMES = 30
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [9:0]  i_x,
   input  logic [9:0]  i_y,
   input  logic        i_de,
   input  logic        i_hsync,
   input  logic        i_vsync,
   input  logic [5:0]  i_cursor_col,
   input  logic [4:0]  i_cursor_row,
   input  logic        i_cursor_en,
   output logic [10:0] o_char_addr,
   input  logic [7:0]  i_char_data,
   output logic [11:0] o_font_addr,
   input  logic [7:0]  i_font_data,
   output logic [2:0]  o_rgb,
   output logic        o_de,
   output logic        o_hsync,
   output logic        o_vsync
);
   localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   typedef struct packed {
      logic       win;
      logic [2:0] pix;
      logic       cur;
      logic       de;
      logic       hs;
      logic       vs;
   } side_t;

   logic [8:0]  dx, dy;
   logic [5:0]  col;
   logic [4:0]  row;
   logic        x_lo_ok, y_lo_ok, in_win, cur_hit, tick, lit;

   logic [10:0]      char_addr_q, char_addr_d;
   logic [11:0]      font_addr_q, font_addr_d;
   logic [3:0]       grow1_q, grow1_d, grow2_q, grow2_d;
   side_t [4:1]      side_q, side_d;
   logic [2:0]       rgb_q, rgb_d;
   logic             de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
   logic             vs_prev_q, vs_prev_d, blink_phase_q, blink_phase_d;
   logic [CW-1:0]    blink_cnt_q, blink_cnt_d;

   // Only the low 9 bits of the offset matter; the window test guards against wrap.
   assign dx  = i_x[8:0] - 9'(X0);
   assign dy  = i_y[8:0] - 9'(Y0);
   assign col = dx[8:3];
   assign row = dy[8:4];

   generate
      if (X0 == 0) begin : g_x_lo_open
         assign x_lo_ok = 1'b1;
      end else begin : g_x_lo_cmp
         assign x_lo_ok = ({1'b0, i_x} >= 11'(X0));
      end
      if (Y0 == 0) begin : g_y_lo_open
         assign y_lo_ok = 1'b1;
      end else begin : g_y_lo_cmp
         assign y_lo_ok = ({1'b0, i_y} >= 11'(Y0));
      end
   endgenerate

   assign in_win = i_de & x_lo_ok & y_lo_ok
                 & ({1'b0, i_x} < 11'(X0 + 8 * COLS))
                 & ({1'b0, i_y} < 11'(Y0 + 16 * ROWS));
   assign cur_hit = i_cursor_en & blink_phase_q & (col == i_cursor_col)
                  & (row == i_cursor_row) & in_win;
   assign tick = i_vsync & ~vs_prev_q;
   assign lit  = i_font_data[3'd7 - side_q[4].pix] ^ side_q[4].cur;

   always_comb begin
      char_addr_d = in_win ? {row, col} : char_addr_q;
      grow1_d     = dy[3:0];
      grow2_d     = grow1_q;
      font_addr_d = {i_char_data, grow2_q};

      side_d[1].win = in_win;
      side_d[1].pix = dx[2:0];
      side_d[1].cur = cur_hit;
      side_d[1].de  = i_de;
      side_d[1].hs  = i_hsync;
      side_d[1].vs  = i_vsync;
      side_d[2]     = side_q[1];
      side_d[3]     = side_q[2];
      side_d[4]     = side_q[3];

      if (!side_q[4].de)       rgb_d = 3'b000;
      else if (!side_q[4].win) rgb_d = BG;
      else                     rgb_d = lit ? FG : BG;
      de_d    = side_q[4].de;
      hsync_d = side_q[4].hs;
      vsync_d = side_q[4].vs;

      // Blink phase only advances on a vsync rising edge, so it is constant across visible lines.
      vs_prev_d     = i_vsync;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (tick) begin
         if (blink_cnt_q == CW'(BLINK_FRAMES - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         char_addr_q   <= '0;
         font_addr_q   <= '0;
         grow1_q       <= '0;
         grow2_q       <= '0;
         side_q        <= '0;
         rgb_q         <= '0;
         de_q          <= 1'b0;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
         vs_prev_q     <= 1'b0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else begin
         char_addr_q   <= char_addr_d;
         font_addr_q   <= font_addr_d;
         grow1_q       <= grow1_d;
         grow2_q       <= grow2_d;
         side_q        <= side_d;
         rgb_q         <= rgb_d;
         de_q          <= de_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         vs_prev_q     <= vs_prev_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   assign o_char_addr = char_addr_q;
   assign o_font_addr = font_addr_q;
   assign o_rgb       = rgb_q;
   assign o_de        = de_q;
   assign o_hsync     = hsync_q;
   assign o_vsync     = vsync_q;
endmodule

// File: tb/tb_text_render.sv
// Bench for text_render: random and directed pixel streams compared against a
// pixel-level reference model with behavioural character RAM and font ROM.
module tb_text_render;
   localparam int         COLS = 60;
   localparam int         ROWS = 17;
   localparam int         X0   = 16;
   localparam int         Y0   = 4;
   localparam int         BF   = 2;
   localparam logic [2:0] FG   = 3'b110;
   localparam logic [2:0] BG   = 3'b001;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  i_x, i_y;
   logic        i_de, i_hsync, i_vsync;
   logic [5:0]  i_cursor_col;
   logic [4:0]  i_cursor_row;
   logic        i_cursor_en;
   logic [10:0] o_char_addr;
   logic [7:0]  i_char_data;
   logic [11:0] o_font_addr;
   logic [7:0]  i_font_data;
   logic [2:0]  o_rgb;
   logic        o_de, o_hsync, o_vsync;

   text_render #(.COLS(COLS), .ROWS(ROWS), .X0(X0), .Y0(Y0), .FG(FG), .BG(BG),
                 .BLINK_FRAMES(BF)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_x(i_x), .i_y(i_y), .i_de(i_de),
      .i_hsync(i_hsync), .i_vsync(i_vsync), .i_cursor_col(i_cursor_col),
      .i_cursor_row(i_cursor_row), .i_cursor_en(i_cursor_en),
      .o_char_addr(o_char_addr), .i_char_data(i_char_data),
      .o_font_addr(o_font_addr), .i_font_data(i_font_data), .o_rgb(o_rgb),
      .o_de(o_de), .o_hsync(o_hsync), .o_vsync(o_vsync));

   always #5 clk = ~clk;

   logic [7:0] char_mem [0:2047];
   logic [7:0] font_mem [0:4095];
   always @(posedge clk) begin
      i_char_data <= char_mem[o_char_addr];
      i_font_data <= font_mem[o_font_addr];
   end

   typedef struct {
      logic [10:0] caddr;
      logic [11:0] font;
      logic [2:0]  rgb;
      logic        de, hs, vs;
   } rec_t;

   rec_t        q[$];
   logic [2:0]  obs_rgb[$];
   int          checks = 0, errors = 0;
   int          rises, fg_count;
   bit          prev_vs;
   logic [10:0] last_caddr;
   logic [2:0]  a_pat [0:7];
   int          exp_fg [0:7];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pixel-level reference: what the screen should show for this input, from cell geometry.
   function automatic rec_t model_pixel(int x, int y, bit de, bit hs, bit vs);
      rec_t r;
      int dx, dy;
      bit win, phase, cur, lit;
      logic [7:0] ch, fb;
      dx    = x - X0;
      dy    = y - Y0;
      win   = de && dx >= 0 && dx < 8 * COLS && dy >= 0 && dy < 16 * ROWS;
      phase = ((rises / BF) % 2) == 1;
      if (win) last_caddr = 11'((dy / 16) * 64 + dx / 8);
      r.caddr = last_caddr;
      ch      = char_mem[last_caddr];
      r.font  = {ch, 4'(dy & 15)};
      if (!de) r.rgb = 3'b000;
      else if (!win) r.rgb = BG;
      else begin
         fb  = font_mem[{ch, 4'(dy & 15)}];
         cur = i_cursor_en && phase && (int'(i_cursor_col) == dx / 8)
               && (int'(i_cursor_row) == dy / 16);
         lit = fb[7 - (dx % 8)] ^ cur;
         r.rgb = lit ? FG : BG;
      end
      r.de = de; r.hs = hs; r.vs = vs;
      if (vs && !prev_vs) rises++;
      prev_vs = vs;
      return r;
   endfunction

   task automatic reset_model();
      rec_t z;
      z.caddr = '0; z.font = {char_mem[0], 4'h0}; z.rgb = '0;
      z.de = 1'b0; z.hs = 1'b0; z.vs = 1'b0;
      q.delete();
      for (int i = 0; i < 5; i++) q.push_back(z);
      rises = 0; prev_vs = 1'b0; last_caddr = '0;
   endtask

   task automatic step(input int x, input int y, input bit de, input bit hs, input bit vs);
      i_x = 10'(x); i_y = 10'(y); i_de = de; i_hsync = hs; i_vsync = vs;
      q.push_back(model_pixel(x, y, de, hs, vs));
      @(posedge clk);
      #1;
      check("char_addr", 32'(o_char_addr), 32'(q[$].caddr));
      check("font_addr", 32'(o_font_addr), 32'(q[$-2].font));
      check("rgb",       32'(o_rgb),       32'(q[$-4].rgb));
      check("de",        32'(o_de),        32'(q[$-4].de));
      check("hsync",     32'(o_hsync),     32'(q[$-4].hs));
      check("vsync",     32'(o_vsync),     32'(q[$-4].vs));
      obs_rgb.push_back(o_rgb);
      if (o_rgb == FG) fg_count++;
      if (q.size() > 8) void'(q.pop_front());
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_char_addr"}, 32'(o_char_addr), 0);
      check({tag, "_font_addr"}, 32'(o_font_addr), 0);
      check({tag, "_rgb"},       32'(o_rgb),       0);
      check({tag, "_de"},        32'(o_de),        0);
      check({tag, "_hsync"},     32'(o_hsync),     0);
      check({tag, "_vsync"},     32'(o_vsync),     0);
   endtask

   initial begin
      logic [7:0] fb;
      a_pat  = '{BG, BG, FG, FG, FG, FG, BG, BG};
      exp_fg = '{0, 0, 128, 128, 0, 0, 0, 0};
      rst_n = 1'b0;
      i_x = '0; i_y = '0; i_de = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0;
      i_cursor_col = '0; i_cursor_row = '0; i_cursor_en = 1'b0;
      for (int i = 0; i < 2048; i++) char_mem[i] = 8'($urandom);
      for (int i = 0; i < 4096; i++) font_mem[i] = 8'($urandom);
      char_mem[0] = 8'h41;
      font_mem[12'h410] = 8'b00111100;
      for (int r = 1; r <= 3; r++)
         for (int c = 2; c <= 4; c++) char_mem[r * 64 + c] = 8'h20;
      for (int i = 0; i < 16; i++) font_mem[12'h200 + i] = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      reset_model();

      // 'A' at cell (0,0), glyph row 0
      obs_rgb.delete();
      for (int k = 0; k < 8; k++) begin
         step(X0 + k, Y0, 1'b1, 1'b0, 1'b0);
         if (k == 0) check("A_char_addr", 32'(o_char_addr), 0);
         if (k == 2) check("A_font_addr", 32'(o_font_addr), 32'h410);
      end
      repeat (4) step(0, 0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) check("A_pixel", 32'(obs_rgb[k + 4]), 32'(a_pat[k]));

      // last column / row-16 address mapping
      step(X0 + 8 * 59 + 3, Y0 + 16 * 16 + 5, 1'b1, 1'b0, 1'b0);
      check("map_char_addr", 32'(o_char_addr), 32'({5'd16, 6'd59}));
      step(0, 0, 1'b0, 1'b0, 1'b0);
      step(0, 0, 1'b0, 1'b0, 1'b0);
      check("map_glyph_row", 32'(o_font_addr[3:0]), 5);
      step(0, 0, 1'b0, 1'b0, 1'b0);
      step(0, 0, 1'b0, 1'b0, 1'b0);
      fb = font_mem[{char_mem[{5'd16, 6'd59}], 4'd5}];
      check("map_pixel_bit3", 32'(o_rgb), 32'(fb[4] ? FG : BG));

      // window edges
      obs_rgb.delete();
      step(X0 - 1, Y0, 1'b1, 1'b0, 1'b0);
      check("left_edge_hold", 32'(o_char_addr), 32'({5'd16, 6'd59}));
      step(X0 + 8 * COLS, Y0, 1'b1, 1'b0, 1'b0);
      check("right_edge_hold", 32'(o_char_addr), 32'({5'd16, 6'd59}));
      step(X0, Y0 + 16, 1'b1, 1'b0, 1'b0);
      check("x0_col0", 32'(o_char_addr), 32'({5'd1, 6'd0}));
      repeat (4) step(0, 0, 1'b0, 1'b0, 1'b0);
      check("left_edge_bg",  32'(obs_rgb[4]), 32'(BG));
      check("right_edge_bg", 32'(obs_rgb[5]), 32'(BG));

      // random pixels, syncs, de and cursor
      for (int k = 0; k < 800; k++) begin
         if (k % 50 == 0) begin
            i_cursor_en  = 1'($urandom);
            i_cursor_col = 6'($urandom);
            i_cursor_row = 5'($urandom);
         end
         step(int'($urandom_range(0, 520)), int'($urandom_range(0, 300)),
              1'($urandom), 1'($urandom), 1'($urandom));
      end

      // asynchronous reset in the middle of a line
      i_cursor_en = 1'b0;
      for (int k = 0; k < 6; k++) step(X0 + k, Y0 + 32, 1'b1, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      i_x = '0; i_y = '0; i_de = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0;
      #1;
      check_all_zero("midline_rst");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      reset_model();
      step(X0, Y0, 1'b1, 1'b0, 1'b0);
      repeat (3) step(0, 0, 1'b0, 1'b0, 1'b0);
      check("resume_de_early", 32'(o_de), 0);
      step(0, 0, 1'b0, 1'b0, 1'b0);
      check("resume_de", 32'(o_de), 1);

      // cursor blink at (3,2) over blank cells; last two frames with cursor disabled
      i_cursor_col = 6'd3;
      i_cursor_row = 5'd2;
      for (int f = 0; f < 8; f++) begin
         i_cursor_en = (f < 6);
         fg_count = 0;
         for (int yy = 0; yy < 48; yy++)
            for (int xx = 0; xx < 24; xx++)
               step(X0 + 16 + xx, Y0 + 16 + yy, 1'b1, 1'b0, 1'b0);
         repeat (4) step(0, 0, 1'b0, 1'b0, 1'b0);
         check($sformatf("blink_frame%0d_fg", f), 32'(fg_count), 32'(exp_fg[f]));
         step(0, 0, 1'b0, 1'b0, 1'b1);
         step(0, 0, 1'b0, 1'b0, 1'b1);
         step(0, 0, 1'b0, 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/text_render.md
Name: text_render

Overview:
- Downstream consumer of the character RAM that the text writers fill.
- Takes raw VGA timing (pixel coordinates, data-enable, syncs) and reads the character at each pixel's cell from the character RAM.
- Fetches the matching glyph row from the font ROM and emits RGB pixels with syncs delayed to match.
- Also draws a blinking block cursor at a given cell.

Parameters:
- COLS, 60, text columns in the window (max 64)
- ROWS, 17, text rows in the window (max 32)
- X0, 0, first pixel column of the text window
- Y0, 0, first pixel row of the text window
- FG, 3'b111, foreground RGB
- BG, 3'b000, background RGB
- BLINK_FRAMES, 30, frames per cursor blink phase (>=1)

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_x  in  10  current pixel column from timing generator
- i_y  in  10  current pixel row from timing generator
- i_de  in  1  active-video flag
- i_hsync  in  1  horizontal sync, passed through
- i_vsync  in  1  vertical sync, passed through; active-high
- i_cursor_col  in  6  cursor column
- i_cursor_row  in  5  cursor row
- i_cursor_en  in  1  cursor visible when 1
- o_char_addr  out  11  character RAM read address {row[4:0], col[5:0]}
- i_char_data  in  8  character RAM data; valid one cycle after o_char_addr (synchronous read)
- o_font_addr  out  12  font ROM address {char[7:0], glyph_row[3:0]}
- i_font_data  in  8  font ROM data; bit 7 = leftmost pixel; valid one cycle after o_font_addr
- o_rgb  out  3  pixel colour
- o_de  out  1  delayed i_de
- o_hsync  out  1  delayed i_hsync
- o_vsync  out  1  delayed i_vsync

Behaviour:
- Reset, asynchronous on i_rst_n low: all outputs 0, all pipeline registers 0, blink counter 0, blink phase 0 (cursor hidden).
- Glyph geometry is fixed at 8x16.
  - dx = i_x - X0, dy = i_y - Y0.
  - col = dx[8:3], row = dy[8:4], glyph_row = dy[3:0], bit = dx[2:0].
- Window test:
  - in_win = i_de & (i_x >= X0) & (i_x < X0+8*COLS) & (i_y >= Y0) & (i_y < Y0+16*ROWS).
  - The comparisons prevent negative dx/dy from wrapping into the window.
- Pipeline: 4 register stages; inputs sampled at edge n appear on outputs after edge n+4.
  - Edge n (S1): o_char_addr <= {row, col}. Also register in_win, glyph_row, bit, cursor-hit, de, hsync, vsync.
  - Edge n+1: the RAM registers its address.
  - Edge n+2 (S2): o_font_addr <= {i_char_data, glyph_row_d}.
  - Edge n+3: the ROM registers its address.
  - Edge n+4 (S4): o_rgb, o_de, o_hsync, o_vsync are registered.
- Outside the window, o_char_addr holds its last value; this is don't-care but must not be X after reset.
- Pixel colour at S4:
  - lit = i_font_data[7 - bit_d] XOR cursor_on_d.
  - o_rgb = !de_d ? 0 : !in_win_d ? BG : (lit ? FG : BG).
- cursor_on at S1: i_cursor_en & blink_phase & (col == i_cursor_col) & (row == i_cursor_row) & in_win. The cursor is inverse video over the whole 8x16 cell.
- Blink counter:
  - Frame tick = rising edge of i_vsync, detected with one registered copy of i_vsync.
  - On a tick: if counter == BLINK_FRAMES-1, then counter <= 0 and blink_phase toggles; else counter increments.
  - blink_phase samples the same value for every pixel of a frame line; a phase change mid-frame is acceptable only during vsync.
- Cursor coordinates outside COLS/ROWS never match, so no cursor is drawn.
- No backpressure: one pixel in and one pixel out per clock, always.
- Reset mid-frame: outputs go to 0 immediately. Valid output resumes 4 cycles after release, with blink restarted hidden.

Test Plan:
- Reset then stream: x=0..7, y=0, de=1, RAM holds 'A' (0x41) at addr 0, font row 0 = 8'b00111100.
  - o_char_addr = 0 one edge after the first pixel.
  - o_font_addr = 12'h410 after 2 edges.
  - o_rgb over 8 pixels = BG,BG,FG,FG,FG,FG,BG,BG, starting 4 edges after x=0.
- Address mapping: x=8*59+3, y=16*16+5 (X0=Y0=0).
  - o_char_addr = {5'd16, 6'd59}.
  - o_font_addr low nibble = 5.
  - Pixel bit 3 selected.
- Window bounds with X0=16: pixels at x=15 and x=16+480 both give o_rgb=BG, with no RAM data appearing; x=16 gives cell col 0.
- Sync alignment: toggle i_hsync, i_vsync and i_de in arbitrary patterns → o_hsync, o_vsync, o_de equal the inputs delayed exactly 4 cycles; o_rgb=0 whenever o_de=0.
- Cursor blink with BLINK_FRAMES=2, cursor at (3,2), cell char 0x20 with an all-zero font.
  - Frames 0–1: that cell renders all BG.
  - After the 2nd vsync rise: all FG.
  - After the 4th vsync rise: BG again.
  - Neighbouring cells stay BG throughout.
  - With i_cursor_en=0: never FG.
- Assert i_rst_n low mid-line → all outputs 0 asynchronously; after release, first valid pixel 4 edges later and cursor hidden until BLINK_FRAMES vsync rises.
